// File: rtl/i2c_burst_seq.sv
// Paced I2C byte-burst sequencer: GAP_CYC idle cycles then one i2c_start per beat, i2c_end advances; no backpressure.
// Read bytes buffer in a BURST_LEN FIFO drained every DRAIN_WAIT cycles; I2C_BURST_SEQ_CHECK_EN enables read-back compare into err_cnt.
module i2c_burst_seq #(
  parameter int unsigned BURST_LEN   = 10,
  parameter int unsigned GAP_CYC     = 5000,
  parameter logic [15:0] START_ADDR  = 16'h0066,
  parameter logic [7:0]  DATA_INIT   = 8'h01,
  parameter int unsigned DRAIN_WAIT  = 500000,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        write,
  input  logic        read,
  input  logic [7:0]  rd_data,
  input  logic        i2c_end,
  output logic        i2c_start,
  output logic        wr_en,
  output logic        rd_en,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [7:0]  fifo_data,
  output logic        fifo_valid
);

  typedef enum logic [1:0] {IDLE, GAP, XFER, DRAIN} state_t;

  localparam int unsigned MAX_A = (GAP_CYC > DRAIN_WAIT) ? GAP_CYC : DRAIN_WAIT;
  localparam int unsigned MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int TW = $clog2(MAX_C + 1);
  localparam int AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_WAIT - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    BEAT_LAST  = 8'(BURST_LEN - 1);

  state_t        state;
  logic [TW-1:0] tmr;
  logic [7:0]    beat_cnt;
  logic [7:0]    mem [BURST_LEN];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    fifo_cnt;
  logic          accept;
  logic          pop;
  logic [7:0]    pop_dat;

  assign accept  = (state == IDLE) && (write || read);
  assign pop     = (state == DRAIN) && (tmr == DRAIN_LAST);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && state == XFER && i2c_end && rd_en) begin
      mem[wr_ptr] <= rd_data;
    end
  end

  // One shared timer: reloaded to 0 on every state entry and every beat/pop.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      tmr        <= '0;
      beat_cnt   <= 8'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= 8'd0;
      i2c_start  <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      fifo_valid <= 1'b0;
      fifo_data  <= 8'd0;
      byte_addr  <= START_ADDR;
      wr_data    <= DATA_INIT;
    end else begin
      i2c_start  <= 1'b0;
      fifo_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wr_en    <= write;
            rd_en    <= !write;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= GAP;
            tmr      <= '0;
            beat_cnt <= 8'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= 8'd0;
          end
        end
        GAP: begin
          if (tmr == GAP_LAST) begin
            i2c_start <= 1'b1;
            state     <= XFER;
            tmr       <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        XFER: begin
          if (i2c_end) begin
            tmr       <= '0;
            beat_cnt  <= beat_cnt + 8'd1;
            byte_addr <= byte_addr + 16'd1;
            if (wr_en) wr_data <= wr_data + 8'd1;
            if (rd_en) begin
              wr_ptr   <= wr_ptr + AW'(1);
              fifo_cnt <= fifo_cnt + 8'd1;
            end
            if (beat_cnt == BEAT_LAST) begin
              wr_en <= 1'b0;
              rd_en <= 1'b0;
              if (rd_en) begin
                state <= DRAIN;
              end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                byte_addr <= START_ADDR;
                wr_data   <= DATA_INIT;
              end
            end else begin
              state <= GAP;
            end
          end else if (tmr == TO_LAST) begin
            // Controller never answered: abandon the burst and drop buffered bytes.
            err       <= 1'b1;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
            tmr       <= '0;
            byte_addr <= START_ADDR;
            wr_data   <= DATA_INIT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= 8'd0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        DRAIN: begin
          if (pop) begin
            fifo_valid <= 1'b1;
            fifo_data  <= pop_dat;
            rd_ptr     <= rd_ptr + AW'(1);
            fifo_cnt   <= fifo_cnt - 8'd1;
            tmr        <= '0;
            if (fifo_cnt == 8'd1) begin
              state     <= IDLE;
              busy      <= 1'b0;
              byte_addr <= START_ADDR;
              wr_data   <= DATA_INIT;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I2C_BURST_SEQ_CHECK_EN
  logic [7:0] exp_byte;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || accept) begin
      err_cnt  <= 8'd0;
      exp_byte <= DATA_INIT;
    end else if (pop) begin
      exp_byte <= exp_byte + 8'd1;
      if (pop_dat != exp_byte && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule
